// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types for the I/D-cache memory-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package arb_types;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Which cache owned the most recent grant.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Purpose: two-way round-robin pick between I-cache and D-cache requests.
// Latency: combinational, 0 cycles.
// Backpressure: none; caller decides when the pick is used.
// Ports: req_i/req_d pending requests, last_grant previous owner,
//        pick_i/pick_d one-hot (or zero) winner.
module arb_rr_pick
    import arb_types::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  arb_owner_t last_grant,
    output logic       pick_i,
    output logic       pick_d
);

    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (req_i && req_d) begin
            // Tie: the side that did not win last time goes now.
            pick_i = (last_grant == OWNER_D);
            pick_d = (last_grant == OWNER_I);
        end else begin
            pick_i = req_i;
            pick_d = req_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one cacheline memory port between I-cache and D-cache, one line at a time.
// Latency: request seen in IDLE -> pmem_* registered next cycle; resp is combinational from pmem_resp.
// Backpressure: requesters hold their request until their resp pulse; loser waits for one
//               transaction plus a RELEASE and an IDLE cycle.
// Ports: i_* I-cache read side, d_* D-cache read/writeback side, pmem_* adaptor side,
//        clk, reset (asynchronous, active low).
module mem_port_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state, state_nxt;
    arb_owner_t last_grant;
    logic       pick_i, pick_d;
    logic       grant_i, grant_d, done;

    arb_rr_pick u_pick (
        .req_i      (i_read),
        .req_d      (d_read | d_write),
        .last_grant (last_grant),
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

    // Next state; requests are only looked at in IDLE, so anything that
    // changes while a grant is live (or during RELEASE) is never sampled.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_i) begin
                    grant_i   = 1'b1;
                    state_nxt = GRANT_I;
                end else if (pick_d) begin
                    grant_d   = 1'b1;
                    state_nxt = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    done      = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transaction latch: captured on the grant edge and held untouched until
    // the completing edge clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            last_grant   <= OWNER_I;
        end else if (grant_i) begin
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= i_addr;
            pmem_wdata   <= '0;
            last_grant   <= OWNER_I;
        end else if (grant_d) begin
            // Writeback wins if the D-cache raises both strobes.
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
            pmem_address <= d_addr;
            pmem_wdata   <= d_wdata;
            last_grant   <= OWNER_D;
        end else if (done) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end
    end

    // Response steering: only the current owner ever sees the adaptor's pulse.
    assign i_resp  = (state == GRANT_I) && pmem_resp;
    assign d_resp  = (state == GRANT_D) && pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter (vector table, corner sequences, random traffic).
// Latency: n/a.
// Backpressure: bench requesters hold requests until their resp pulse.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Wait (bounded) until a transaction is presented on the pmem port.
    task automatic wait_grant(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            seen = pmem_read | pmem_write;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no grant within 12 cycles (got none, expected grant)", nm);
        end
    endtask

    typedef struct {
        logic          ird;
        logic [AW-1:0] ia;
        logic          drd;
        logic          dwr;
        logic [AW-1:0] da;
        logic [7:0]    wd;
        logic          rsp;
        logic [7:0]    rd;
        logic          e_pr;
        logic          e_pw;
        logic [AW-1:0] e_pa;
        logic [7:0]    e_wd;
        logic          e_ir;
        logic          e_dr;
    } vec_t;

    vec_t vt[18];

    // Random-section model state
    int            m_busy, m_last, m_done;
    logic          e_pr, e_pw, exp_ir, exp_dr, win_d, got_i, got_d;
    logic [AW-1:0] e_pa;
    logic [LW-1:0] e_wd;
    logic          s_i, s_d, s_w;
    logic [AW-1:0] s_ia, s_da;
    logic [LW-1:0] s_wd;
    int            r;

    initial begin
        // ird ia drd dwr da wd rsp rd | e_pr e_pw e_pa e_wd e_ir e_dr
        vt[0]  = '{1, 'h60, 0, 0, 'h0,   8'h00, 0, 8'h00, 0, 0, 'h0,   8'h00, 0, 0};
        vt[1]  = '{1, 'h60, 0, 0, 'h0,   8'h00, 0, 8'h00, 1, 0, 'h60,  8'h00, 0, 0};
        vt[2]  = '{1, 'h60, 0, 0, 'h0,   8'h00, 1, 8'hAA, 1, 0, 'h60,  8'h00, 1, 0};
        vt[3]  = '{0, 'h60, 0, 0, 'h0,   8'h00, 0, 8'h00, 0, 0, 'h0,   8'h00, 0, 0};
        vt[4]  = '{0, 'h0,  0, 0, 'h0,   8'h00, 0, 8'h00, 0, 0, 'h0,   8'h00, 0, 0};
        vt[5]  = '{1, 'h100,0, 1, 'h200, 8'h5C, 0, 8'h00, 0, 0, 'h0,   8'h00, 0, 0};
        vt[6]  = '{1, 'h100,0, 1, 'h200, 8'h5C, 0, 8'h00, 0, 1, 'h200, 8'h5C, 0, 0};
        vt[7]  = '{1, 'h100,0, 1, 'h200, 8'h5C, 1, 8'hBB, 0, 1, 'h200, 8'h5C, 0, 1};
        vt[8]  = '{1, 'h100,0, 0, 'h200, 8'h5C, 0, 8'h00, 0, 0, 'h0,   8'h00, 0, 0};
        vt[9]  = '{1, 'h100,0, 0, 'h200, 8'h5C, 0, 8'h00, 0, 0, 'h0,   8'h00, 0, 0};
        vt[10] = '{1, 'h100,0, 0, 'h200, 8'h5C, 0, 8'h00, 1, 0, 'h100, 8'h00, 0, 0};
        vt[11] = '{1, 'h100,0, 0, 'h200, 8'h5C, 1, 8'hCC, 1, 0, 'h100, 8'h00, 1, 0};
        vt[12] = '{0, 'h0,  0, 0, 'h0,   8'h00, 0, 8'h00, 0, 0, 'h0,   8'h00, 0, 0};
        vt[13] = '{0, 'h0,  1, 1, 'h40,  8'h33, 1, 8'hDD, 0, 0, 'h0,   8'h00, 0, 0};
        vt[14] = '{0, 'h0,  1, 1, 'h40,  8'h33, 0, 8'h00, 0, 1, 'h40,  8'h33, 0, 0};
        vt[15] = '{0, 'h0,  1, 1, 'h40,  8'h33, 1, 8'hEE, 0, 1, 'h40,  8'h33, 0, 1};
        vt[16] = '{0, 'h0,  0, 0, 'h0,   8'h00, 1, 8'h11, 0, 0, 'h0,   8'h00, 0, 0};
        vt[17] = '{0, 'h0,  0, 0, 'h0,   8'h00, 1, 8'h22, 0, 0, 'h0,   8'h00, 0, 0};

        // Reset state
        #2;
        chk("rst_pmem_read",  pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr",  pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_i_resp",     i_resp, 0);
        chk("rst_d_resp",     d_resp, 0);
        reset_dut();

        // Vector table: tests 1, 2 and 6
        for (int n = 0; n < 18; n++) begin
            @(posedge clk); #1;
            i_read  = vt[n].ird;  i_addr = vt[n].ia;
            d_read  = vt[n].drd;  d_write = vt[n].dwr; d_addr = vt[n].da;
            d_wdata = {32{vt[n].wd}};
            pmem_resp  = vt[n].rsp;
            pmem_rdata = {32{vt[n].rd}};
            @(negedge clk);
            chk($sformatf("vec%0d_pmem_read", n),  pmem_read,    vt[n].e_pr);
            chk($sformatf("vec%0d_pmem_write", n), pmem_write,   vt[n].e_pw);
            chk($sformatf("vec%0d_pmem_addr", n),  pmem_address, vt[n].e_pa);
            chk($sformatf("vec%0d_pmem_wdata", n), pmem_wdata,   {32{vt[n].e_wd}});
            chk($sformatf("vec%0d_i_resp", n),     i_resp,       vt[n].e_ir);
            chk($sformatf("vec%0d_d_resp", n),     d_resp,       vt[n].e_dr);
            chk($sformatf("vec%0d_i_rdata", n),    i_rdata,      vt[n].e_ir ? {32{vt[n].rd}} : '0);
            chk($sformatf("vec%0d_d_rdata", n),    d_rdata,      vt[n].e_dr ? {32{vt[n].rd}} : '0);
            if (vt[n].drd && vt[n].dwr && n == 13)
                $display("note: d_read and d_write raised together, write expected to win");
        end
        @(posedge clk); #1;
        idle_inputs();

        // Test 3: continuous contention after reset -> D,I,D,I,D,I
        reset_dut();
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 'h100;
        d_read = 1'b1; d_addr = 'h200;
        for (int k = 0; k < 6; k++) begin
            wait_grant($sformatf("t3_grant%0d", k));
            chk($sformatf("t3_owner%0d", k), pmem_address, (k % 2 == 0) ? 'h200 : 'h100);
            @(posedge clk); #1;
            pmem_resp = 1'b1; pmem_rdata = {32{8'h5A}};
            @(negedge clk);
            chk($sformatf("t3_i_resp%0d", k), i_resp, (k % 2 == 1));
            chk($sformatf("t3_d_resp%0d", k), d_resp, (k % 2 == 0));
            chk($sformatf("t3_one_resp%0d", k), i_resp & d_resp, 0);
            @(posedge clk); #1;
            pmem_resp = 1'b0;
        end
        idle_inputs();
        repeat (3) @(posedge clk);

        // Test 4: d_addr changes mid GRANT_D
        #1;
        d_write = 1'b1; d_addr = 'h200; d_wdata = {32{8'h77}};
        wait_grant("t4_grant");
        @(posedge clk); #1;
        d_addr = 'h300;
        repeat (2) begin
            @(negedge clk);
            chk("t4_addr_held", pmem_address, 'h200);
            chk("t4_write_held", pmem_write, 1);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t4_d_resp", d_resp, 1);
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(posedge clk);

        // Test 5: reset during GRANT_I, then stray pmem_resp
        #1;
        i_read = 1'b1; i_addr = 'h60;
        wait_grant("t5_grant");
        chk("t5_pmem_read_before", pmem_read, 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("t5_async_pmem_read", pmem_read, 0);
        chk("t5_async_pmem_addr", pmem_address, 0);
        @(posedge clk); #1;
        i_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b1; pmem_rdata = {32{8'h99}};
        @(negedge clk);
        chk("t5_no_i_resp", i_resp, 0);
        chk("t5_no_i_rdata", i_rdata, 0);
        chk("t5_pmem_read_idle", pmem_read, 0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("t5_still_idle", pmem_read | pmem_write, 0);

        // Random traffic against a transaction-level model
        reset_dut();
        m_busy = 0; m_last = 1; m_done = -3; got_i = 0; got_d = 0;
        e_pr = 0; e_pw = 0; e_pa = '0; e_wd = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            s_i = i_read; s_d = d_read | d_write; s_w = d_write;
            s_ia = i_addr; s_da = d_addr; s_wd = d_wdata;
            #1;
            if (got_i) i_read = 1'b0;
            else if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
            end
            if (got_d) begin
                d_read = 1'b0; d_write = 1'b0;
            end else if (!(d_read | d_write) && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 7);
                d_read  = (r < 4) || (r == 7);
                d_write = (r >= 4);
                d_addr  = $urandom & 32'hFFFF_FFE0;
                d_wdata = rand_line();
            end
            if (pmem_read | pmem_write) pmem_resp = ($urandom_range(0, 2) == 0);
            else                        pmem_resp = ($urandom_range(0, 15) == 0);
            pmem_rdata = rand_line();
            @(negedge clk);
            // Port is free again two cycles after a completion; a waiting request
            // then shows up on the port the cycle after that.
            if (m_busy == 0 && c >= m_done + 3 && (s_i || s_d)) begin
                win_d  = s_d && (!s_i || m_last == 1);
                m_busy = win_d ? 2 : 1;
                m_last = m_busy;
                e_pa = win_d ? s_da : s_ia;
                e_pw = win_d && s_w;
                e_pr = !e_pw;
                e_wd = win_d ? s_wd : '0;
            end
            if (m_busy != 0) begin
                chk("rnd_pmem_read",  pmem_read,    e_pr);
                chk("rnd_pmem_write", pmem_write,   e_pw);
                chk("rnd_pmem_addr",  pmem_address, e_pa);
                chk("rnd_pmem_wdata", pmem_wdata,   e_wd);
            end else begin
                chk("rnd_idle_port", {pmem_read, pmem_write}, 0);
            end
            exp_ir = (m_busy == 1) && pmem_resp;
            exp_dr = (m_busy == 2) && pmem_resp;
            chk("rnd_i_resp",  i_resp,  exp_ir);
            chk("rnd_d_resp",  d_resp,  exp_dr);
            chk("rnd_i_rdata", i_rdata, exp_ir ? pmem_rdata : '0);
            chk("rnd_d_rdata", d_rdata, exp_dr ? pmem_rdata : '0);
            got_i = exp_ir;
            got_d = exp_dr;
            if (pmem_resp && m_busy != 0) begin
                m_busy = 0;
                m_done = c;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
